// File: rtl/sequence_detector_moore_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sequence_detector_moore_pkg
// Purpose  : State encoding and pattern constant for the 1011 Moore detector.
// Revision : 1.0
// ============================================================================
package sequence_detector_moore_pkg;

  // Each state names the longest useful suffix of the bits seen so far.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    MATCH = 3'd4
  } state_t;

  // Oldest bit in the MSB: the first bit received is 1.
  localparam logic [3:0] c_pattern = 4'b1011;

endpackage : sequence_detector_moore_pkg
`default_nettype wire

// File: rtl/sequence_detector_moore_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sequence_detector_moore_if
// Purpose  : Serial input and detection flag between a stream source and the detector.
// Revision : 1.0
// ============================================================================
interface sequence_detector_moore_if;

  logic sequence_in;
  logic detector_out;

  modport master (
    output sequence_in,
    input  detector_out
  );

  modport slave (
    input  sequence_in,
    output detector_out
  );

endinterface : sequence_detector_moore_if
`default_nettype wire

// File: rtl/sequence_detector_moore.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sequence_detector_moore
// Purpose  : Moore FSM flagging each (overlapping) 1-0-1-1 in a serial stream.
// Revision : 1.0
// ============================================================================
module sequence_detector_moore
  import sequence_detector_moore_pkg::*;
(
  input  wire                          clock,
  input  wire                          reset,
  sequence_detector_moore_if.slave     bus
);

  state_t r_state;
  state_t w_next_state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Fall-back transitions reuse the longest suffix that is still a prefix of 1011.
  always_comb begin
    w_next_state = IDLE;
    case (r_state)
      IDLE:    w_next_state = bus.sequence_in ? S1    : IDLE;
      S1:      w_next_state = bus.sequence_in ? S1    : S10;
      S10:     w_next_state = bus.sequence_in ? S101  : IDLE;
      S101:    w_next_state = bus.sequence_in ? MATCH : S10;
      MATCH:   w_next_state = bus.sequence_in ? S1    : S10;
      default: w_next_state = IDLE;
    endcase
  end

  assign bus.detector_out = (r_state == MATCH);

endmodule : sequence_detector_moore
`default_nettype wire

// File: tb/tb_sequence_detector_moore.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sequence_detector_moore
// Purpose  : Directed and randomized checks of the 1011 Moore detector.
// Revision : 1.0
// ============================================================================
module tb_sequence_detector_moore;
  import sequence_detector_moore_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  // Reference history: bits sampled since the last reset, newest in bit 0.
  logic [3:0] hist;
  int         hist_cnt;

  sequence_detector_moore_if bus ();

  sequence_detector_moore dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<1000000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input logic expected, input string tag);
    checks++;
    assert (bus.detector_out === expected)
      else begin
        errors++;
        $error("FAIL %s: detector_out=%b expected=%b at %0t", tag, bus.detector_out, expected, $time);
      end
  endtask

  // Drive a bit, let the next rising edge sample it, then check the registered flag.
  task automatic tick(input logic b, input logic expected, input string tag);
    bus.sequence_in = b;
    @(posedge clock);
    #1;
    check(expected, tag);
  endtask

  // Asynchronous reset pulse placed between edges; the flag must clear immediately.
  task automatic async_reset_pulse(input string tag);
    #1;
    reset = 1'b1;
    #2;
    check(1'b0, tag);
    #1;
    reset = 1'b0;
    hist     = 4'b0000;
    hist_cnt = 0;
  endtask

  task automatic model_tick(input logic b, input string tag);
    logic exp;
    hist     = {hist[2:0], b};
    hist_cnt = hist_cnt + 1;
    exp      = (hist_cnt >= 4) && (hist == c_pattern);
    tick(b, exp, tag);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    hist        = 4'b0000;
    hist_cnt    = 0;
    reset       = 1'b1;
    bus.sequence_in = 1'b0;

    // 1. Reset hold with the input toggling, then quiet input after release.
    tick(1'b1, 1'b0, "reset_hold0");
    tick(1'b0, 1'b0, "reset_hold1");
    tick(1'b1, 1'b0, "reset_hold2");
    reset = 1'b0;
    tick(1'b0, 1'b0, "post_reset0");
    tick(1'b0, 1'b0, "post_reset1");
    tick(1'b0, 1'b0, "post_reset2");
    tick(1'b0, 1'b0, "post_reset3");

    // 2. Single match: 0,1,0,1,1,0.
    tick(1'b0, 1'b0, "single0");
    tick(1'b1, 1'b0, "single1");
    tick(1'b0, 1'b0, "single2");
    tick(1'b1, 1'b0, "single3");
    tick(1'b1, 1'b1, "single4_match");
    tick(1'b0, 1'b0, "single5");

    // 3. Overlap: 1,0,1,1,0,1,1 gives pulses three cycles apart.
    async_reset_pulse("reset_before_overlap");
    tick(1'b1, 1'b0, "overlap0");
    tick(1'b0, 1'b0, "overlap1");
    tick(1'b1, 1'b0, "overlap2");
    tick(1'b1, 1'b1, "overlap3_match");
    tick(1'b0, 1'b0, "overlap4");
    tick(1'b1, 1'b0, "overlap5");
    tick(1'b1, 1'b1, "overlap6_match");

    // 4. Near-misses, then a match reached through S101 -0-> S10.
    async_reset_pulse("reset_before_near");
    tick(1'b1, 1'b0, "near_a0");
    tick(1'b0, 1'b0, "near_a1");
    tick(1'b0, 1'b0, "near_a2");
    tick(1'b1, 1'b0, "near_a3");
    tick(1'b1, 1'b0, "near_a4");
    tick(1'b1, 1'b0, "near_b0");
    tick(1'b1, 1'b0, "near_b1");
    tick(1'b1, 1'b0, "near_b2");
    tick(1'b1, 1'b0, "near_b3");
    tick(1'b1, 1'b0, "near_c0");
    tick(1'b0, 1'b0, "near_c1");
    tick(1'b1, 1'b0, "near_c2");
    tick(1'b0, 1'b0, "near_c3");
    tick(1'b1, 1'b0, "near_c4");
    tick(1'b1, 1'b1, "near_c5_match");

    // 5. Reset mid-pattern discards the 101 prefix.
    async_reset_pulse("reset_before_mid");
    tick(1'b1, 1'b0, "mid0");
    tick(1'b0, 1'b0, "mid1");
    tick(1'b1, 1'b0, "mid2");
    async_reset_pulse("mid_reset");
    tick(1'b1, 1'b0, "mid_after_reset");
    tick(1'b1, 1'b0, "mid_full0");
    tick(1'b0, 1'b0, "mid_full1");
    tick(1'b1, 1'b0, "mid_full2");
    tick(1'b1, 1'b1, "mid_full3_match");

    // 6. Random soak against the shift-register reference.
    async_reset_pulse("reset_before_soak");
    for (int i = 0; i < 1000; i++) begin
      if ((i % 250) == 249) begin
        async_reset_pulse("soak_reset");
      end
      model_tick(1'($urandom_range(0, 1)), "soak");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sequence_detector_moore
`default_nettype wire
